// File: rtl/mult_unit_pkg.sv
// Shared definitions for the execute-stage multiplier: ALU operation codes and FSM states.
// The optional early-termination feature is selected with MULT_EARLY_TERM_EN (see mult_unit).
package mult_unit_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SRL = 4'd4,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    MULT_OP = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: accumulator, shifted multiplicand and shifted multiplier registers.
// MULT_EARLY_TERM_EN adds a flag reporting that the multiplier has no set bits left.
module mult_datapath #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] acc_upd
`ifdef MULT_EARLY_TERM_EN
  ,
  output logic              b_next_zero
`endif
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] a_sh_q, a_sh_d;
  logic [DATA_W-1:0] b_sh_q, b_sh_d;

  // Sum wraps modulo 2**DATA_W; only the low word of the product is kept.
  assign acc_upd = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;

`ifdef MULT_EARLY_TERM_EN
  assign b_next_zero = ((b_sh_q >> 1) == '0);
`endif

  always_comb begin
    acc_d  = acc_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    if (load) begin
      acc_d  = '0;
      a_sh_d = op_a;
      b_sh_d = op_b;
    end else if (step) begin
      acc_d  = acc_upd;
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
    end else begin
      acc_q  <= acc_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
    end
  end

endmodule

// File: rtl/mult_unit.sv
// Iterative multiplier beside the ALU: low DATA_W bits of op_a*op_b, stalling the pipeline meanwhile.
// Define MULT_EARLY_TERM_EN to leave BUSY as soon as the remaining multiplier bits are all zero.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        dbg_state
);

  // Handshake: an operation is accepted in the cycle stall rises from IDLE; the
  // result is valid exactly in the single cycle done=1 (stall is low then), and
  // stays on result until the next accept. flush cancels without raising done.

  mult_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] acc_upd;
  logic              accept;
  logic              step;
  logic              last_iter;

  assign accept = (state_q == IDLE) && start && (alu_control == MULT_OP) && !flush;

`ifdef MULT_EARLY_TERM_EN
  logic b_next_zero;
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1)) || b_next_zero;
`else
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));
`endif

  mult_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .clk         (clk),
    .arst        (arst),
    .load        (accept),
    .step        (step),
    .op_a        (op_a),
    .op_b        (op_b),
    .acc_upd     (acc_upd)
`ifdef MULT_EARLY_TERM_EN
    ,
    .b_next_zero (b_next_zero)
`endif
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    step     = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    // flush overrides everything: no iteration, no done, result untouched
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            stall   = 1'b1;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          stall = 1'b1;
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            result_d = acc_upd;
            state_d  = DONE;
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
